// File: rtl/branch_resolver.sv
// Branch/jump resolver: forms base+offset targets, decides taken, owns the pc,
// and hands one registered result per accepted instruction downstream.
module branch_resolver #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [1:0]  branch_op,
    input  logic [2:0]  branch_base_src,
    input  logic [2:0]  branch_offset_src,
    input  logic [31:0] rs1_data,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        flush,
    output logic [31:0] pc,
    output logic        fault,
    input  logic        fault_clear
);
    typedef enum logic {RUN, FAULT} state_t;
    state_t state, state_nx;

    logic [31:0] imm_i, imm_b, imm_j;
    logic [31:0] base, offset, sum, target, pc_plus4, npc;
    logic        taken_c, misalign, accept;
    logic        unused_instr;

    assign unused_instr = ^instr[6:0];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        base = 32'd0;
        case (branch_base_src)
            3'b001:  base = pc_plus4;
            3'b010:  base = pc;
            3'b011:  base = rs1_data;
            default: base = 32'd0;
        endcase
    end

    always_comb begin
        offset = 32'd0;
        case (branch_offset_src)
            3'b100:  offset = imm_i;
            3'b101:  offset = imm_j;
            3'b110:  offset = imm_b;
            default: offset = 32'd0;
        endcase
    end

    // Register-relative jumps drop bit 0 of the sum, JALR style.
    assign sum    = base + offset;
    assign target = (branch_base_src == 3'b011) ? {sum[31:1], 1'b0} : sum;

    // X/Z ops fall to the default arm, so they resolve as never-taken.
    always_comb begin
        taken_c = 1'b0;
        case (branch_op)
            2'b01:   taken_c = !alu_zero;
            2'b10:   taken_c = alu_zero;
            2'b11:   taken_c = 1'b1;
            default: taken_c = 1'b0;
        endcase
    end

    assign npc      = taken_c ? target : pc_plus4;
    assign misalign = taken_c && target[1];
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign fault    = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (accept && misalign) state_nx = FAULT;
            FAULT:   if (fault_clear)        state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            next_pc   <= 32'd0;
            taken     <= 1'b0;
            out_valid <= 1'b0;
            flush     <= 1'b0;
        end else if (accept && !misalign) begin
            pc        <= npc;
            next_pc   <= npc;
            taken     <= taken_c;
            out_valid <= 1'b1;
            flush     <= taken_c;
        end else begin
            // A misaligned accept still retires any result handed off this cycle.
            flush <= 1'b0;
            if (out_ready || accept || state == FAULT) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed vectors checked with
// immediate assertions, one summary line at the end.
module tb_branch_resolver;
    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, rs1_data;
    logic [1:0]  branch_op;
    logic [2:0]  branch_base_src, branch_offset_src;
    logic        alu_zero, out_valid, out_ready;
    logic [31:0] next_pc, pc;
    logic        taken, flush, fault, fault_clear;

    int n_vec = 0;
    int n_err = 0;

    branch_resolver #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .branch_op(branch_op), .branch_base_src(branch_base_src),
        .branch_offset_src(branch_offset_src), .rs1_data(rs1_data), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc), .taken(taken),
        .flush(flush), .pc(pc), .fault(fault), .fault_clear(fault_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] bsrc, input logic [2:0] osrc,
                         input logic [31:0] ins, input logic [31:0] rs1, input logic az);
        branch_op = op; branch_base_src = bsrc; branch_offset_src = osrc;
        instr = ins; rs1_data = rs1; alu_zero = az; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] e_npc, input logic e_tk,
                          input logic e_fl, input logic [31:0] e_pc);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".next_pc"}, next_pc, e_npc);
        chk({tag, ".taken"}, {31'd0, taken}, {31'd0, e_tk});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
        chk({tag, ".pc"}, pc, e_pc);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fault_clear = 1'b0;
        instr = '0; rs1_data = '0; branch_op = 2'b00; alu_zero = 1'b0;
        branch_base_src = 3'b000; branch_offset_src = 3'b000;
        tick();
        chk("rst.pc", pc, RPC);
        chk("rst.next_pc", next_pc, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.flush_taken_fault", {29'd0, flush, taken, fault}, 32'd0);
        rst_n = 1'b1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Unknown op never branches even with a valid target
        issue(2'bxx, 3'b000, 3'b100, 32'h1000_0000, 32'd0, 1'b0);
        result("xop", 32'h44, 1'b0, 1'b0, 32'h44);

        issue(2'b11, 3'b000, 3'b100, 32'h1000_0000, 32'd0, 1'b0);
        result("jmp100", 32'h100, 1'b1, 1'b1, 32'h100);
        tick();
        chk("jmp100.drain", {30'd0, out_valid, flush}, 32'd0);

        issue(2'b00, 3'b001, 3'b110, 32'hFE00_0C80, 32'd0, 1'b1);
        result("seq", 32'h104, 1'b0, 1'b0, 32'h104);
        tick();

        // Unlisted offset code contributes zero: target = pc
        issue(2'b11, 3'b010, 3'b111, 32'hFFFF_FFFF, 32'd0, 1'b0);
        result("offunl", 32'h104, 1'b1, 1'b1, 32'h104);
        tick();

        issue(2'b11, 3'b000, 3'b100, 32'h2000_0000, 32'd0, 1'b0);
        tick();
        chk("jmp200.pc", pc, 32'h200);
        issue(2'b10, 3'b001, 3'b110, 32'hFE00_0C80, 32'd0, 1'b1);
        result("beq", 32'h1FC, 1'b1, 1'b1, 32'h1FC);
        tick();
        chk("beq.flush_once", {30'd0, out_valid, flush}, 32'd0);

        issue(2'b01, 3'b010, 3'b101, 32'h0100_0000, 32'd0, 1'b0);
        result("bne_j", 32'h20C, 1'b1, 1'b1, 32'h20C);
        issue(2'b10, 3'b010, 3'b101, 32'h0100_0000, 32'd0, 1'b0);
        result("beq_nt", 32'h210, 1'b0, 1'b0, 32'h210);
        tick();

        issue(2'b11, 3'b011, 3'b100, 32'h0010_0000, 32'h1003, 1'b0);
        result("jalr", 32'h1004, 1'b1, 1'b1, 32'h1004);
        tick();
        issue(2'b11, 3'b011, 3'b100, 32'h0010_0000, 32'h1001, 1'b0);
        chk("mis.fault", {31'd0, fault}, 32'd1);
        chk("mis.pc", pc, 32'h1004);
        chk("mis.next_pc", next_pc, 32'h1004);
        chk("mis.rdy_vld", {30'd0, in_ready, out_valid}, 32'd0);
        issue(2'b11, 3'b000, 3'b100, 32'h2000_0000, 32'd0, 1'b0);
        chk("flt.hold", {31'd0, fault}, 32'd1);
        chk("flt.pc", pc, 32'h1004);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("clr.fault", {31'd0, fault}, 32'd0);
        chk("clr.in_ready", {31'd0, in_ready}, 32'd1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("run.clr_ignored", {30'd0, fault, in_ready}, 32'd1);

        out_ready = 1'b0;
        issue(2'b11, 3'b000, 3'b100, 32'h4000_0000, 32'd0, 1'b0);
        result("bp.first", 32'h400, 1'b1, 1'b1, 32'h400);
        for (int i = 0; i < 3; i++) begin
            branch_op = 2'b00; in_valid = 1'b1;
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            result("bp.stall", 32'h400, 1'b1, 1'b0, 32'h400);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        result("bp.b2b", 32'h404, 1'b0, 1'b0, 32'h404);
        tick();
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        issue(2'b11, 3'b000, 3'b100, 32'hFFC0_0000, 32'd0, 1'b0);
        chk("wrap.pc", pc, 32'hFFFF_FFFC);
        issue(2'b00, 3'b000, 3'b000, 32'd0, 32'd0, 1'b0);
        result("wrap", 32'h0, 1'b0, 1'b0, 32'h0);

        out_ready = 1'b0;
        issue(2'b11, 3'b000, 3'b100, 32'h1000_0000, 32'd0, 1'b0);
        chk("mid.out_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.out_valid_rst", {31'd0, out_valid}, 32'd0);
        chk("mid.pc", pc, RPC);
        chk("mid.next_pc", next_pc, 32'd0);
        chk("mid.flags", {29'd0, flush, taken, fault}, 32'd0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        issue(2'b00, 3'b000, 3'b000, 32'd0, 32'd0, 1'b0);
        result("post_rst", 32'h44, 1'b0, 1'b0, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the pc value loaded on reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  upstream holds a decoded instruction.
REQ-005 SHALL have port in_ready  out  1  resolver accepts this cycle.
REQ-006 SHALL have port instr  in  32  raw instruction, source of immediates.
REQ-007 SHALL have port branch_op  in  2  00 never, 01 ALU non-zero, 10 ALU zero, 11 always.
REQ-008 SHALL have port branch_base_src  in  3  000 zero, 001 pc+4, 010 pc, 011 rs1_data.
REQ-009 SHALL have port branch_offset_src  in  3  000 zero, 100 I-imm, 101 J-imm, 110 B-imm.
REQ-010 SHALL have port rs1_data  in  32  register operand.
REQ-011 SHALL have port alu_zero  in  1  ALU result equals zero.
REQ-012 SHALL have port out_valid  out  1  resolved result available.
REQ-013 SHALL have port out_ready  in  1  downstream consumes result.
REQ-014 SHALL have port next_pc  out  32  resolved address of next instruction.
REQ-015 SHALL have port taken  out  1  resolved branch taken.
REQ-016 SHALL have port flush  out  1  one-cycle pulse: discard fetched wrong-path instruction.
REQ-017 SHALL have port pc  out  32  current instruction address.
REQ-018 SHALL have port fault  out  1  misaligned taken target, sticky.
REQ-019 SHALL have port fault_clear  in  1  leave fault state.

Function
REQ-020 SHALL have states RUN and FAULT; no other states.
REQ-021 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-022 SHALL, on accept (in_valid && in_ready), compute target = base + offset, 32-bit modulo; wrap-around not flagged.
REQ-023 SHALL use immediates: I = sext(instr[31:20]); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-024 SHALL treat unlisted base/offset codes as zero and branch_op containing X/Z as never.
REQ-025 SHALL clear target bit 0 when branch_base_src is 011.
REQ-026 SHALL resolve taken: never 0; non-zero !alu_zero; zero alu_zero; always 1.
REQ-027 SHALL set next_pc = taken ? target : pc+4.
REQ-028 SHALL, on accept, register next_pc, taken, and out_valid=1 with one-cycle latency, and load pc <= next_pc on the same edge.
REQ-029 SHALL pulse flush for exactly the first cycle of out_valid when taken=1.
REQ-030 SHALL hold out_valid, next_pc, and taken stable while out_valid && !out_ready.
REQ-031 SHALL clear out_valid after a handshake without a concurrent accept.
REQ-032 SHALL, on a concurrent handshake and accept, replace the result back-to-back with no bubble.
REQ-033 SHALL, when taken && target[1]==1, not update pc or outputs, and enter FAULT with fault=1 from the next cycle.
REQ-034 SHALL, in FAULT, hold in_ready=0 and out_valid=0, and return to RUN with fault=0 one cycle after fault_clear=1.
REQ-035 SHALL ignore fault_clear in RUN.

Reset
REQ-036 SHALL, on rst_n low, immediately set pc=RESET_PC, next_pc=0, taken=0, out_valid=0, flush=0, fault=0, state=RUN.
REQ-037 SHALL discard any pending result on reset mid-operation.
REQ-038 SHALL assert in_ready on the first edge after rst_n deasserts.

Verification
REQ-039 SHALL verify sequential: pc=0x100, op=00 -> next_pc=0x104, taken=0, flush=0, pc=0x104.
REQ-040 SHALL verify BEQ: pc=0x200, base 001, B-imm=-8, alu_zero=1, op=10 -> next_pc=0x1FC, taken=1, one-cycle flush.
REQ-041 SHALL verify JALR: rs1_data=0x1003, I-imm=+1, base 011 -> next_pc=0x1004; rs1_data=0x1001 with I-imm=+1 -> FAULT, pc unchanged, fault_clear restores RUN.
REQ-042 SHALL verify backpressure: out_ready=0 for 3 cycles -> in_ready=0 and outputs stable; raising out_ready alongside in_valid -> back-to-back accept.
REQ-043 SHALL verify wrap: pc=0xFFFF_FFFC, op=00 -> next_pc=0x0000_0000.
REQ-044 SHALL verify reset: assert rst_n low while out_valid=1 -> out_valid=0 and pc=RESET_PC immediately.
